// File: rtl/layer_pkg.sv
// Shared constants and FSM state type for the layer datapath and its input loader.
package layer_pkg;

  localparam int unsigned LAYER_IN_W  = 20;
  localparam int unsigned LAYER_OUT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ld_state_e;

endpackage

// File: rtl/layer_input_loader_if.sv
// Host serial pin triple plus the loaded-vector outputs toward the layer.
interface layer_input_loader_if
  import layer_pkg::*;
#(
  parameter int unsigned WIDTH = LAYER_IN_W
);

  logic             ser_clk_i;
  logic             ser_data_i;
  logic             ser_frame_i;
  logic [WIDTH-1:0] vec_o;
  logic             vec_valid_o;
  logic             frame_err_o;

  // Host side: drives the serial pins, observes the loaded vector.
  modport master (
    output ser_clk_i, ser_data_i, ser_frame_i,
    input  vec_o, vec_valid_o, frame_err_o
  );

  // Loader side.
  modport slave (
    input  ser_clk_i, ser_data_i, ser_frame_i,
    output vec_o, vec_valid_o, frame_err_o
  );

endinterface

// File: rtl/layer_input_loader_sync_edge.sv
// Multi-flop synchronizer for one async pin with rise/fall pulses on the synced level.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the pin through the chain and keep a one-clock delayed copy of its output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/layer_input_loader.sv
// Assembles a framed serial bit stream into a registered WIDTH-bit layer input vector.
module layer_input_loader
  import layer_pkg::*;
#(
  parameter int unsigned WIDTH       = LAYER_IN_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  layer_input_loader_if.slave bus
);

  localparam int unsigned       CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_OVR  = CNT_W'(WIDTH + 1);

  logic sclk_s,  sclk_rise,  sclk_fall;
  logic sdata_s, sdata_rise, sdata_fall;
  logic sfrm_s,  sfrm_rise,  sfrm_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .d_i(bus.ser_clk_i),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst(rst), .d_i(bus.ser_data_i),
    .q_o(sdata_s), .rise_o(sdata_rise), .fall_o(sdata_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_frame (
    .clk(clk), .rst(rst), .d_i(bus.ser_frame_i),
    .q_o(sfrm_s), .rise_o(sfrm_rise), .fall_o(sfrm_fall)
  );

  // Edge/level outputs of the shared synchronizer that this block has no use for.
  logic unused_sync;
  assign unused_sync = ^{sclk_s, sclk_fall, sdata_rise, sdata_fall};

  ld_state_e        state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] vec_q;
  logic             valid_q;
  logic             err_q;

  // Frame FSM: collect bits while framed, then commit or flag the frame for one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (sfrm_rise) begin
            state_q <= ST_SHIFT;
            shreg_q <= '0;
            cnt_q   <= '0;
          end
        end
        ST_SHIFT: begin
          // A ser_clk rise coinciding with the frame fall sees sfrm_s low and is dropped.
          if (sfrm_fall) begin
            state_q <= ST_DONE;
          end else if (sclk_rise && sfrm_s) begin
            shreg_q <= {shreg_q[WIDTH-2:0], sdata_s};
            if (cnt_q != CNT_OVR) cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (cnt_q == CNT_FULL) begin
            vec_q   <= shreg_q;
            valid_q <= 1'b1;
            err_q   <= 1'b0;
          end else begin
            err_q   <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.vec_o       = vec_q;
  assign bus.vec_valid_o = valid_q;
  assign bus.frame_err_o = err_q;

endmodule

// File: tb/tb_layer_input_loader.sv
// Self-checking bench for layer_input_loader: directed cases plus random frames vs a frame-level model.
module tb_layer_input_loader;
  import layer_pkg::*;

  localparam int unsigned W   = 20;
  localparam int          SYN = 2;
  localparam int          LAT = SYN + 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  layer_input_loader_if #(.WIDTH(W)) bus ();

  layer_input_loader #(.WIDTH(W), .SYNC_STAGES(SYN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_mis = 0;

  // Reference model state: what the layer should currently see.
  logic [W-1:0] exp_vec;
  logic         exp_err;
  bit           exp_good;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.ser_data_i = b;
    wait_clks(4);
    bus.ser_clk_i = 1'b1;
    wait_clks(4);
    bus.ser_clk_i = 1'b0;
  endtask

  // Watch vec_valid_o for a bounded window after the frame pin falls.
  task automatic observe(input int window, output int pulses, output int lat);
    pulses = 0;
    lat    = -1;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      if (bus.vec_valid_o === 1'b1) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  // n bits of val, MSB first; coinc puts one extra ser_clk rise on the same clock as the frame fall.
  task automatic send_frame(input logic [31:0] val, input int n, input bit coinc,
                            input int window, output int pulses, output int lat);
    bus.ser_frame_i = 1'b1;
    wait_clks(4);
    for (int i = 0; i < n; i++) send_bit(val[n-1-i]);
    if (coinc) begin
      bus.ser_data_i = ~val[0];
      wait_clks(4);
      bus.ser_clk_i   = 1'b1;
      bus.ser_frame_i = 1'b0;
      observe(window, pulses, lat);
      bus.ser_clk_i   = 1'b0;
    end else begin
      wait_clks(4);
      bus.ser_frame_i = 1'b0;
      observe(window, pulses, lat);
    end
  endtask

  // Frame-level rule: exactly W bits replaces the vector, anything else flags an error.
  task automatic model_frame(input logic [31:0] val, input int n);
    logic bits[$];
    logic [W-1:0] v;
    for (int i = 0; i < n; i++) bits.push_back(val[n-1-i]);
    exp_good = (bits.size() == W);
    if (exp_good) begin
      v = '0;
      foreach (bits[i]) v = {v[W-2:0], bits[i]};
      exp_vec = v;
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic check_frame(input string tag, input int pulses, input int lat);
    chk({tag, "_vec"},    32'(bus.vec_o), 32'(exp_vec));
    chk({tag, "_err"},    32'(bus.frame_err_o), 32'(exp_err));
    chk({tag, "_pulses"}, 32'(pulses), exp_good ? 32'd1 : 32'd0);
    if (exp_good) chk({tag, "_lat"}, 32'(lat), 32'(LAT));
  endtask

  task automatic run_frame(input string tag, input logic [31:0] val, input int n);
    int p, l;
    send_frame(val, n, 1'b0, 10, p, l);
    model_frame(val, n);
    check_frame(tag, p, l);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

  initial begin
    int p, l, p2, l2;
    logic [31:0] rv;
    int rn;

    rst             = 1'b1;
    bus.ser_clk_i   = 1'b0;
    bus.ser_data_i  = 1'b0;
    bus.ser_frame_i = 1'b0;
    exp_vec = '0;
    exp_err = 1'b0;
    wait_clks(3);
    chk("rst_vec",   32'(bus.vec_o), 32'd0);
    chk("rst_valid", 32'(bus.vec_valid_o), 32'd0);
    chk("rst_err",   32'(bus.frame_err_o), 32'd0);
    rst = 1'b0;
    wait_clks(3);

    // Case 1: good frame.
    run_frame("c1", 32'h000A5C3F, 20);
    // Case 2: short frame then good frame.
    run_frame("c2_short", 32'h0007FFFF, 19);
    run_frame("c2_good",  32'h00000001, 20);
    // Case 3: overrun.
    run_frame("c3_long",  32'h00654321, 23);

    // Case 4: reset in the middle of a frame with the frame pin held high.
    bus.ser_frame_i = 1'b1;
    wait_clks(4);
    for (int i = 0; i < 10; i++) send_bit(1'(i & 1));
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    chk("c4_rst_vec", 32'(bus.vec_o), 32'd0);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    wait_clks(4);
    bus.ser_frame_i = 1'b0;
    observe(10, p, l);
    exp_vec  = '0;
    exp_err  = 1'b1;
    exp_good = 1'b0;
    check_frame("c4", p, l);

    // Case 5: 21st ser_clk rise lands on the frame fall and must be ignored.
    send_frame(32'h00012345, 20, 1'b1, 10, p, l);
    model_frame(32'h00012345, 20);
    check_frame("c5", p, l);
    wait_clks(4);

    // Case 6: back-to-back frames with the minimum 4-clock gap.
    send_frame(32'h000FFFFF, 20, 1'b0, 4, p, l);
    send_frame(32'h00000000, 20, 1'b0, 10, p2, l2);
    chk("c6_pulses", 32'(p + p2), 32'd2);
    chk("c6_lat1",   32'(l), 32'(LAT));
    model_frame(32'h000FFFFF, 20);
    model_frame(32'h00000000, 20);
    chk("c6_vec", 32'(bus.vec_o), 32'd0);
    chk("c6_err", 32'(bus.frame_err_o), 32'd0);

    // Random frames: mostly well-formed, some of arbitrary length.
    for (int t = 0; t < 14; t++) begin
      rv = $urandom;
      rn = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 24)) : int'(W);
      run_frame($sformatf("rnd%0d", t), rv, rn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
